// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    // Bits needed to index n items (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible index starting at rr_ptr.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]            eligible,
    input  logic [idx_width(NUM_REQ)-1:0] rr_ptr,
    output logic [idx_width(NUM_REQ)-1:0] winner,
    output logic                          any_valid
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    int unsigned idx;

    // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and keep the first hit.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any_valid && eligible[idx]) begin
                any_valid = 1'b1;
                winner    = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with credit-based occupancy tracking and a drain handshake.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ-1:0]               req_mask,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             fifo_wr_en,
    output logic [DATA_WIDTH-1:0]            fifo_data_in,
    input  logic                             fifo_full,
    input  logic                             fifo_empty,
    input  logic                             fifo_rd_en,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    input  logic                             flush_req,
    output logic                             flush_done,
    output logic                             err_overflow
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CW    = cnt_width(FIFO_DEPTH);

    arb_state_t        state, state_next;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  winner;
    logic [CW-1:0]     credits;
    logic [NUM_REQ-1:0] eligible;
    logic              any_valid;
    logic              grant_ok;
    logic              rd_acc;
    logic              drain_done;

    assign eligible = req_valid & ~req_mask;
    assign rd_acc   = fifo_rd_en && !fifo_empty;
    assign level    = CW'(FIFO_DEPTH) - credits;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Grant decision and one-hot ready toward the winning producer.
    always_comb begin
        grant_ok  = (state == RUN) && !flush_req && (credits != '0) && any_valid;
        req_ready = '0;
        if (grant_ok) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Next-state logic: RUN enters DRAIN on flush_req; DRAIN exits once all credits return.
    always_comb begin
        state_next = state;
        drain_done = 1'b0;
        case (state)
            RUN: begin
                if (flush_req) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((credits == CW'(FIFO_DEPTH)) && !fifo_wr_en) begin
                    drain_done = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Credit counter: a grant consumes one credit, an accepted read returns one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits <= CW'(FIFO_DEPTH);
        end else if (grant_ok && !rd_acc) begin
            credits <= credits - CW'(1);
        end else if (rd_acc && !grant_ok && (credits != CW'(FIFO_DEPTH))) begin
            credits <= credits + CW'(1);
        end
    end

    // Round-robin pointer advances past the winner on every grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_ok) begin
            rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end
    end

    // Registered write port; data and id hold between writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            grant_id     <= '0;
        end else begin
            fifo_wr_en <= grant_ok;
            if (grant_ok) begin
                fifo_data_in <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                grant_id     <= winner;
            end
        end
    end

    // One-cycle flush_done pulse and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_done   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            flush_done   <= drain_done;
            err_overflow <= err_overflow | (fifo_wr_en && fifo_full);
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed testbench for fifo_write_arbiter with a small downstream FIFO model.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [1:0]  grant_id;
    logic [2:0]  level;
    logic        flush_req;
    logic        flush_done;
    logic        err_overflow;

    int n_vec;
    int n_err;
    int fcnt;

    localparam logic [7:0] D0 = 8'hA5;
    localparam logic [7:0] D1 = 8'h3C;
    localparam logic [7:0] D2 = 8'h5A;
    localparam logic [7:0] D3 = 8'hC3;

    fifo_write_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_mask     (req_mask),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .grant_id     (grant_id),
        .level        (level),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-entry FIFO occupancy model
    always @(posedge clk) begin
        if (!rst_n) fcnt <= 0;
        else fcnt <= fcnt + (fifo_wr_en ? 1 : 0) - ((fifo_rd_en && fcnt != 0) ? 1 : 0);
    end
    assign fifo_full  = (fcnt == 4);
    assign fifo_empty = (fcnt == 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_mask   = '0;
        req_data   = {D3, D2, D1, D0};
        fifo_rd_en = 1'b0;
        flush_req  = 1'b0;

        // Reset
        step(); step();
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_data", 32'(fifo_data_in), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_fdone", 32'(flush_done), 0);
        chk("rst_err", 32'(err_overflow), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        step(); step();
        chk("idle_wr_en", 32'(fifo_wr_en), 0);
        chk("idle_level", 32'(level), 0);

        // Round-robin through all four producers
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(1 << i));
            step();
            chk("rr_wr_en", 32'(fifo_wr_en), 1);
            chk("rr_gid", 32'(grant_id), 32'(i));
            chk("rr_data", 32'(fifo_data_in), 32'(req_data[i*8 +: 8]));
            chk("rr_level", 32'(level), 32'(i + 1));
        end
        #1;
        chk("rr_full_ready", 32'(req_ready), 0);
        req_valid = '0;
        step();
        chk("rr_stop_wr_en", 32'(fifo_wr_en), 0);
        chk("rr_stop_level", 32'(level), 4);

        // Full hold: no credits, producer 1 must wait for a read
        req_valid = 4'b0010;
        #1;
        chk("hold_ready", 32'(req_ready), 0);
        step();
        chk("hold_wr_en", 32'(fifo_wr_en), 0);
        fifo_rd_en = 1'b1;
        step();
        fifo_rd_en = 1'b0;
        #1;
        chk("hold_rd_level", 32'(level), 3);
        chk("hold_rd_ready", 32'(req_ready), 32'h2);
        step();
        chk("hold_wr_en2", 32'(fifo_wr_en), 1);
        chk("hold_gid", 32'(grant_id), 1);
        chk("hold_data", 32'(fifo_data_in), 32'(D1));
        chk("hold_level", 32'(level), 4);
        req_valid = '0;

        // Mask/skip: rr_ptr=2, producer 3 masked -> producer 0
        fifo_rd_en = 1'b1;
        step(); step();
        fifo_rd_en = 1'b0;
        chk("mask_pre_level", 32'(level), 2);
        req_valid = 4'b1001;
        req_mask  = 4'b1000;
        #1;
        chk("mask_ready", 32'(req_ready), 32'h1);
        step();
        chk("mask_gid", 32'(grant_id), 0);
        chk("mask_data", 32'(fifo_data_in), 32'(D0));
        chk("mask_level", 32'(level), 3);
        req_valid = '0;
        req_mask  = '0;

        // Simultaneous grant and read at level 2
        fifo_rd_en = 1'b1;
        step();
        chk("sim_pre_level", 32'(level), 2);
        req_valid = 4'b0011;
        #1;
        chk("sim_rrptr1_ready", 32'(req_ready), 32'h2);
        step();
        chk("sim_gid1", 32'(grant_id), 1);
        chk("sim_data1", 32'(fifo_data_in), 32'(D1));
        chk("sim_level1", 32'(level), 2);
        #1;
        chk("sim_ready2", 32'(req_ready), 32'h1);
        step();
        chk("sim_gid2", 32'(grant_id), 0);
        chk("sim_data2", 32'(fifo_data_in), 32'(D0));
        chk("sim_level2", 32'(level), 2);
        req_valid  = '0;
        fifo_rd_en = 1'b0;
        step();
        chk("sim_idle_wr_en", 32'(fifo_wr_en), 0);
        chk("sim_idle_level", 32'(level), 2);

        // Flush from level 3
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        chk("fl_pre_level", 32'(level), 3);
        step();
        req_valid = 4'b1111;
        flush_req = 1'b1;
        #1;
        chk("fl_req_ready", 32'(req_ready), 0);
        step();
        flush_req = 1'b0;
        chk("fl_req_wr_en", 32'(fifo_wr_en), 0);
        fifo_rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fl_drain_ready", 32'(req_ready), 0);
            chk("fl_drain_done", 32'(flush_done), 0);
            step();
        end
        fifo_rd_en = 1'b0;
        chk("fl_empty_level", 32'(level), 0);
        chk("fl_wait_done", 32'(flush_done), 0);
        step();
        chk("fl_done_pulse", 32'(flush_done), 1);
        chk("fl_run_ready", 32'(req_ready), 32'h2);
        step();
        chk("fl_done_clear", 32'(flush_done), 0);
        chk("fl_resume_wr", 32'(fifo_wr_en), 1);
        chk("fl_resume_gid", 32'(grant_id), 1);
        chk("err_sticky", 32'(err_overflow), 0);

        // Reset mid-operation drops the registered write
        rst_n = 1'b0;
        step();
        chk("midrst_wr_en", 32'(fifo_wr_en), 0);
        chk("midrst_level", 32'(level), 0);
        rst_n     = 1'b1;
        req_valid = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
